// File: rtl/imem_pkg.sv
// imem_pkg -- shared definitions for the synchronous instruction memory.
//   NOP            : instruction returned for faulting fetches
//   FAULT_MISALIGN : rsp_fault bit set when the byte address is not word aligned
//   FAULT_RANGE    : rsp_fault bit set when the word index is >= DEPTH
//   rsp_t          : response record at the default 32/32 widths
//   even_par()     : even-parity bit over a (zero-extended) word
package imem_pkg;

    localparam logic [31:0] NOP            = 32'h0000_0000;
    localparam int          FAULT_MISALIGN = 0;
    localparam int          FAULT_RANGE    = 1;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] addr;
        logic [1:0]  fault;
        logic        perr;
    } rsp_t;

    // Zero-extension does not change parity, so callers may pass any width <= 64.
    function automatic logic even_par(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/imem_rsp_queue.sv
// imem_rsp_queue -- 2-entry in-order FIFO of response records.
//   clk, reset : clock, synchronous active-high flush
//   push, din  : enqueue din at the edge
//   pop        : dequeue the head at the edge (only when !empty)
//   head       : oldest entry, held stable until popped
//   empty      : no entries stored
// Entry 0 is always the head; a pop shifts entry 1 down.
import imem_pkg::*;

module imem_rsp_queue #(
    parameter type T = rsp_t
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pop,
    input  T     din,
    output T     head,
    output logic empty
);

    T           ent0;
    T           ent1;
    logic [1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt  <= 2'd0;
            ent0 <= '0;
            ent1 <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (cnt == 2'd0) ent0 <= din;
                    else             ent1 <= din;
                    cnt <= cnt + 2'd1;
                end
                2'b01: begin
                    ent0 <= ent1;
                    cnt  <= cnt - 2'd1;
                end
                2'b11: begin
                    // Count is unchanged; the new entry lands behind whatever remains.
                    if (cnt == 2'd1) begin
                        ent0 <= din;
                    end else begin
                        ent0 <= ent1;
                        ent1 <= din;
                    end
                end
                default: ;
            endcase
        end
    end

    assign head  = ent0;
    assign empty = (cnt == 2'd0);

endmodule

// File: rtl/imem_sync.sv
// imem_sync -- synchronous instruction memory with a valid/ready fetch port,
// a 2-deep in-order response queue and a word-write load port.
//   clk, reset          : clock, synchronous active-high reset
//   req_valid/req_ready : fetch handshake, req_addr = byte address
//   rsp_valid/rsp_ready : response handshake
//   rsp_instr/rsp_addr  : fetched word (NOP on fault) and echoed address
//   rsp_fault           : bit0 misaligned, bit1 out-of-range
//   rsp_perr            : parity mismatch on the fetched word
//   ld_en/ld_addr/ld_data/ld_par_flip : word write port, optional parity inversion
// Optional feature: define IMEM_PARITY_EN to store and check a parity bit per word.
//
// Pipeline: an accepted request reads the array at the accept edge; the result
// sits in a one-cycle "s1" stage. If the queue is empty, s1 is presented
// directly (1-cycle latency); otherwise, or if not consumed, s1 is pushed into
// the queue at the next edge. The credit counter bounds queue + s1 to 2, so a
// push always finds room.
import imem_pkg::*;

module imem_sync #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int DEPTH  = 256,
    parameter int IDX_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_instr,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [1:0]        rsp_fault,
    output logic              rsp_perr,
    input  logic              ld_en,
    input  logic [IDX_W-1:0]  ld_addr,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_par_flip
);

    localparam int WIDX_W = ADDR_W - 2;

    typedef struct packed {
        logic [DATA_W-1:0] instr;
        logic [ADDR_W-1:0] addr;
        logic [1:0]        fault;
        logic              perr;
    } pkt_t;

    // ---------------- request decode ----------------
    logic [WIDX_W-1:0] widx;
    logic [IDX_W-1:0]  rd_idx;
    logic [1:0]        req_fault;
    logic              accept;
    logic              rd_en;
    logic              ld_ok;

    assign widx   = req_addr[ADDR_W-1:2];
    assign rd_idx = widx[IDX_W-1:0];

    always_comb begin
        req_fault                 = 2'b00;
        req_fault[FAULT_MISALIGN] = (req_addr[1:0] != 2'b00);
        req_fault[FAULT_RANGE]    = (widx >= WIDX_W'(DEPTH));
    end

    assign accept = req_valid && req_ready;
    assign rd_en  = accept && (req_fault == 2'b00);   // faulting fetches never touch the array
    assign ld_ok  = ld_en && (32'(ld_addr) < DEPTH);

    // ---------------- storage ----------------
    // No reset on the array or its read register: contents survive reset and
    // the read register is only meaningful for a non-faulting s1 entry.
    // Read and write share one NBA block, so a same-word load is seen by the
    // fetch only on the following access (read-before-write).
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] rdata;

    always_ff @(posedge clk) begin
        if (ld_ok) mem[ld_addr] <= ld_data;
        if (rd_en) rdata <= mem[rd_idx];
    end

`ifdef IMEM_PARITY_EN
    logic mem_par [DEPTH];
    logic rpar;

    always_ff @(posedge clk) begin
        if (ld_ok) mem_par[ld_addr] <= even_par(64'(ld_data)) ^ ld_par_flip;
        if (rd_en) rpar <= mem_par[rd_idx];
    end
`else
    logic unused_par_flip;
    assign unused_par_flip = ld_par_flip;
`endif

    // ---------------- s1: read in flight ----------------
    logic              s1_valid;
    logic [ADDR_W-1:0] s1_addr;
    logic [1:0]        s1_fault;
    pkt_t              s1_pkt;

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_addr  <= '0;
            s1_fault <= 2'b00;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_addr  <= req_addr;
                s1_fault <= req_fault;
            end
        end
    end

    always_comb begin
        s1_pkt       = '0;
        s1_pkt.addr  = s1_addr;
        s1_pkt.fault = s1_fault;
        if (s1_fault != 2'b00) begin
            s1_pkt.instr = DATA_W'(NOP);
            s1_pkt.perr  = 1'b0;
        end else begin
            s1_pkt.instr = rdata;
`ifdef IMEM_PARITY_EN
            s1_pkt.perr  = (rpar != even_par(64'(rdata)));
`else
            s1_pkt.perr  = 1'b0;
`endif
        end
    end

    // ---------------- response queue ----------------
    logic q_empty;
    logic q_push;
    logic q_pop;
    pkt_t q_head;
    pkt_t head;
    logic rsp_fire;

    // s1 goes straight out when nothing older is waiting and it is taken now.
    assign q_pop  = !q_empty && rsp_ready;
    assign q_push = s1_valid && !(q_empty && rsp_ready);

    imem_rsp_queue #(.T(pkt_t)) u_rsp_queue (
        .clk   (clk),
        .reset (reset),
        .push  (q_push),
        .pop   (q_pop),
        .din   (s1_pkt),
        .head  (q_head),
        .empty (q_empty)
    );

    assign head      = q_empty ? s1_pkt : q_head;
    assign rsp_valid = !q_empty || s1_valid;
    assign rsp_fire  = rsp_valid && rsp_ready;

    // Idle outputs read as zero so reset values hold without extra registers.
    assign rsp_instr = rsp_valid ? head.instr : '0;
    assign rsp_addr  = rsp_valid ? head.addr  : '0;
    assign rsp_fault = rsp_valid ? head.fault : 2'b00;
    assign rsp_perr  = rsp_valid ? head.perr  : 1'b0;

    // ---------------- credits ----------------
    // cred = queued + in-flight. req_ready depends only on this register and
    // reset, never on rsp_ready, which costs one bubble when draining from full.
    logic [1:0] cred;

    always_ff @(posedge clk) begin
        if (reset) cred <= 2'd0;
        else       cred <= cred + {1'b0, accept} - {1'b0, rsp_fire};
    end

    assign req_ready = !reset && (cred < 2'd2);

endmodule

// File: tb/tb_imem_sync.sv
// tb_imem_sync -- scoreboard bench for imem_sync: stimulus pushes expected
// responses, a negedge monitor pops and compares on every rsp handshake.
// Honours IMEM_PARITY_EN for the expected rsp_perr.
`timescale 1ns/1ps
module tb_imem_sync;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_instr;
    logic [31:0] rsp_addr;
    logic [1:0]  rsp_fault;
    logic        rsp_perr;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;
    logic        ld_par_flip;

    imem_sync #(.DATA_W(32), .ADDR_W(32), .DEPTH(256)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_instr(rsp_instr), .rsp_addr(rsp_addr),
        .rsp_fault(rsp_fault), .rsp_perr(rsp_perr),
        .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .ld_par_flip(ld_par_flip)
    );

    always #5 clk = ~clk;

`ifdef IMEM_PARITY_EN
    localparam logic PAR_ON = 1'b1;
`else
    localparam logic PAR_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] instr;
        logic [31:0] addr;
        logic [1:0]  fault;
        logic        perr;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted response is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_rsp: got addr %h with empty scoreboard", rsp_addr);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("rsp_instr", 64'(rsp_instr), 64'(e.instr));
                chk("rsp_addr",  64'(rsp_addr),  64'(e.addr));
                chk("rsp_fault", 64'(rsp_fault), 64'(e.fault));
                chk("rsp_perr",  64'(rsp_perr),  64'(e.perr));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [7:0] idx, input logic [31:0] d, input logic flip);
        ld_en = 1'b1; ld_addr = idx; ld_data = d; ld_par_flip = flip;
        tick();
        ld_en = 1'b0; ld_par_flip = 1'b0;
    endtask

    // Present a fetch, wait (bounded) for req_ready, record the expectation, accept.
    task automatic fetch(input logic [31:0] a, input logic [31:0] ei,
                         input logic [1:0] ef, input logic ep);
        int n;
        exp_t e;
        n = 0;
        req_valid = 1'b1;
        req_addr  = a;
        while (!req_ready && n < 50) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            n_cmp++;
            n_err++;
            $display("FAIL fetch_timeout: req_ready stayed 0 for addr %h", a);
        end else begin
            e.instr = ei; e.addr = a; e.fault = ef; e.perr = ep;
            sb.push_back(e);
            tick();
        end
        req_valid = 1'b0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 20) begin
            tick();
            n++;
        end
        chk(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        int acc;
        reset = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
        ld_en = 1'b0; ld_addr = '0; ld_data = '0; ld_par_flip = 1'b0;
        tick();
        chk("ready_in_reset", 64'(req_ready), 64'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("reset_req_ready", 64'(req_ready), 64'd1);
        chk("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("reset_rsp_instr", 64'(rsp_instr), 64'd0);
        chk("reset_rsp_addr",  64'(rsp_addr),  64'd0);
        chk("reset_rsp_fault", 64'(rsp_fault), 64'd0);
        chk("reset_rsp_perr",  64'(rsp_perr),  64'd0);

        // Back-to-back fetches, 1-cycle latency each.
        load(8'd0, 32'h0000_4A00, 1'b0);
        load(8'd1, 32'h10E4_FFFC, 1'b0);
        fetch(32'h0, 32'h0000_4A00, 2'b00, 1'b0);
        chk("lat_first", 64'(rsp_valid), 64'd1);
        fetch(32'h4, 32'h10E4_FFFC, 2'b00, 1'b0);
        chk("lat_second", 64'(rsp_valid), 64'd1);
        chk("sustain_ready", 64'(req_ready), 64'd1);
        drain("drain_b2b");

        // Faults: NOP, perr 0, in order.
        fetch(32'h0000_0002, 32'h0, 2'b01, 1'b0);
        fetch(32'h0000_0400, 32'h0, 2'b10, 1'b0);
        fetch(32'h0000_0401, 32'h0, 2'b11, 1'b0);
        drain("drain_fault");

        // Backpressure: continuous requests, exactly two accepted.
        rsp_ready = 1'b0;
        req_valid = 1'b1;
        req_addr  = 32'h0;
        acc = 0;
        for (int c = 0; c < 6; c++) begin
            if (req_ready) begin
                exp_t e;
                e.instr = 32'h0000_4A00; e.addr = 32'h0; e.fault = 2'b00; e.perr = 1'b0;
                sb.push_back(e);
                acc++;
            end
            tick();
        end
        req_valid = 1'b0;
        chk("bp_accepts",   64'(acc),       64'd2);
        chk("bp_ready_low", 64'(req_ready), 64'd0);
        chk("bp_head_vld",  64'(rsp_valid), 64'd1);
        chk("bp_head_data", 64'(rsp_instr), 64'h0000_4A00);
        chk("bp_head_addr", 64'(rsp_addr),  64'h0);
        rsp_ready = 1'b1;
        tick();
        chk("bp_ready_back", 64'(req_ready), 64'd1);
        drain("drain_bp");
        chk("bp_idle", 64'(rsp_valid), 64'd0);

        // Read-before-write on the same word.
        load(8'd5, 32'h1111_1111, 1'b0);
        ld_en = 1'b1; ld_addr = 8'd5; ld_data = 32'h00A4_380A;
        fetch(32'h14, 32'h1111_1111, 2'b00, 1'b0);
        ld_en = 1'b0;
        fetch(32'h14, 32'h00A4_380A, 2'b00, 1'b0);
        drain("drain_rbw");

        // Reset with two responses queued; a load in the reset cycle still lands.
        rsp_ready = 1'b0;
        fetch(32'h0, 32'h0000_4A00, 2'b00, 1'b0);
        fetch(32'h4, 32'h10E4_FFFC, 2'b00, 1'b0);
        chk("pre_reset_full", 64'(req_ready), 64'd0);
        reset = 1'b1;
        sb.delete();
        ld_en = 1'b1; ld_addr = 8'd7; ld_data = 32'hCAFE_0007;
        #1;
        chk("mid_reset_ready", 64'(req_ready), 64'd0);
        tick();
        reset = 1'b0;
        ld_en = 1'b0;
        #1;
        chk("post_reset_valid", 64'(rsp_valid), 64'd0);
        chk("post_reset_ready", 64'(req_ready), 64'd1);
        rsp_ready = 1'b1;
        fetch(32'h0,  32'h0000_4A00, 2'b00, 1'b0);
        fetch(32'h1C, 32'hCAFE_0007, 2'b00, 1'b0);
        drain("drain_reset");

        // Parity error injection.
        load(8'd3, 32'h1234_5678, 1'b1);
        fetch(32'hC, 32'h1234_5678, 2'b00, PAR_ON);
        load(8'd3, 32'h1234_5678, 1'b0);
        fetch(32'hC, 32'h1234_5678, 2'b00, 1'b0);
        drain("drain_par");

        tick();
        chk("final_idle", 64'(rsp_valid), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
